// File: rtl/regfile_port_sequencer.sv
// Client-side sequencer for the 32x32 register file: arbitrates operand fetch
// against writeback on the single port pair and hands operand pairs to execute.
module regfile_port_sequencer #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [4:0]  op_rs1,
   input  logic [4:0]  op_rs2,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        rf_read_en,
   output logic        rf_write_en,
   output logic [4:0]  rf_rs1_addr,
   output logic [4:0]  rf_rs2_addr,
   output logic [4:0]  rf_write_addr,
   output logic [31:0] rf_write_data,
   input  logic [31:0] rf_rs1_data,
   input  logic [31:0] rf_rs2_data,
   output logic        opnd_valid,
   input  logic        opnd_ready,
   output logic [31:0] opnd_rs1,
   output logic [31:0] opnd_rs2
);
   localparam int unsigned XW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

   state_t        state, state_next;
   logic [AW-1:0] h_rs1, h_rs2;
   logic [SW-1:0] sc, sc_next;
   logic          slot_free, starve, wb_fire, rd_fire;

   assign rf_rs1_addr   = op_rs1;
   assign rf_rs2_addr   = op_rs2;
   assign rf_write_addr = wb_rd;
   assign rf_write_data = wb_data;
   assign opnd_valid    = (state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Port arbitration and next-state; the RF sees these on the handshake edge.
   always_comb begin
      state_next  = state;
      sc_next     = sc;
      slot_free   = (state == IDLE) || ((state == HOLD) && opnd_ready);
      starve      = op_valid && slot_free && (sc == SW'(STARVE_LIMIT));
      wb_ready    = !rst && !starve;
      wb_fire     = wb_valid && wb_ready;
      op_ready    = !rst && slot_free && !wb_fire;
      rd_fire     = op_valid && op_ready;
      rf_write_en = wb_fire && (wb_rd != '0);
      rf_read_en  = rd_fire;

      if (rd_fire || !op_valid)
         sc_next = '0;
      else if (slot_free && wb_fire && (sc != SW'(STARVE_LIMIT)))
         sc_next = sc + SW'(1);

      case (state)
         IDLE:    if (rd_fire) state_next = RD;
         RD:      state_next = HOLD;
         HOLD:    if (opnd_ready) state_next = rd_fire ? RD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand value at capture: x0 reads zero, a same-cycle write beats stale RF data.
   function automatic logic [XW-1:0] capture(input logic [AW-1:0] idx,
                                             input logic [XW-1:0] rf_val);
      if (idx == '0)                          return '0;
      else if (rf_write_en && wb_rd == idx)   return wb_data;
      else                                    return rf_val;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_rs1    <= '0;
         h_rs2    <= '0;
         sc       <= '0;
         opnd_rs1 <= '0;
         opnd_rs2 <= '0;
      end else begin
         sc <= sc_next;
         if (rd_fire) begin
            h_rs1 <= op_rs1;
            h_rs2 <= op_rs2;
         end
         if (state == RD) begin
            opnd_rs1 <= capture(h_rs1, rf_rs1_data);
            opnd_rs2 <= capture(h_rs2, rf_rs2_data);
         end else if (state == HOLD) begin
            if (rf_write_en && wb_rd == h_rs1) opnd_rs1 <= wb_data;
            if (rf_write_en && wb_rd == h_rs2) opnd_rs2 <= wb_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Randomized bench for regfile_port_sequencer: behavioural register-file
// environment plus an architectural-state reference model.
module tb_regfile_port_sequencer;
   localparam int unsigned LIMIT = 4;

   logic        clk, rst;
   logic        op_valid, op_ready;
   logic [4:0]  op_rs1, op_rs2;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        rf_read_en, rf_write_en;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_write_addr;
   logic [31:0] rf_write_data, rf_rs1_data, rf_rs2_data;
   logic        opnd_valid, opnd_ready;
   logic [31:0] opnd_rs1, opnd_rs2;

   regfile_port_sequencer #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_rs1(op_rs1), .op_rs2(op_rs2),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
      .opnd_rs1(opnd_rs1), .opnd_rs2(opnd_rs2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: read data is meaningful only the cycle after a read.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (rf_read_en && !rf_write_en) begin
         rf_rs1_data <= mem[rf_rs1_addr];
         rf_rs2_data <= mem[rf_rs2_addr];
      end else begin
         rf_rs1_data <= $urandom;
         rf_rs2_data <= $urandom;
      end
      if (rf_write_en && !rf_read_en) mem[rf_write_addr] = rf_write_data;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: architectural registers plus one outstanding request.
   logic [31:0] arch [32];
   bit          pending;
   int          age;
   logic [4:0]  mh1, mh2;
   int          losses;
   bit          slot, e_wbr, e_wfire, e_opr, e_rd, e_we, e_ov;

   task automatic cycle();
      @(negedge clk);
      slot    = !pending || (age >= 2 && opnd_ready);
      e_wbr   = !(op_valid && slot && losses == int'(LIMIT));
      e_wfire = wb_valid && e_wbr;
      e_opr   = slot && !e_wfire;
      e_rd    = op_valid && e_opr;
      e_we    = e_wfire && (wb_rd != 5'd0);
      e_ov    = pending && age >= 2;
      check("op_ready",    op_ready,    e_opr);
      check("wb_ready",    wb_ready,    e_wbr);
      check("rf_read_en",  rf_read_en,  e_rd);
      check("rf_write_en", rf_write_en, e_we);
      check("both_en",     rf_read_en & rf_write_en, 0);
      check("opnd_valid",  opnd_valid,  e_ov);
      if (e_ov) begin
         check("opnd_rs1", opnd_rs1, arch[mh1]);
         check("opnd_rs2", opnd_rs2, arch[mh2]);
      end
      if (e_we) begin
         check("wr_addr", rf_write_addr, wb_rd);
         check("wr_data", rf_write_data, wb_data);
      end
      if (e_rd) begin
         check("rd_addr1", rf_rs1_addr, op_rs1);
         check("rd_addr2", rf_rs2_addr, op_rs2);
      end
      @(posedge clk);
      if (e_we) arch[wb_rd] = wb_data;
      if (e_ov && opnd_ready) pending = 0;
      else if (pending && age < 2) age++;
      if (e_rd) begin
         pending = 1; age = 1; mh1 = op_rs1; mh2 = op_rs2;
      end
      if (!op_valid || e_rd) losses = 0;
      else if (slot && e_wfire && losses < int'(LIMIT)) losses++;
      #1;
   endtask

   task automatic drive(input int p_op, input int p_wb, input int p_rdy);
      op_valid   = ($urandom_range(99, 0) < p_op);
      op_rs1     = 5'($urandom_range(7, 0));
      op_rs2     = 5'($urandom_range(7, 0));
      wb_valid   = ($urandom_range(99, 0) < p_wb);
      wb_rd      = 5'($urandom_range(7, 0));
      wb_data    = $urandom;
      opnd_ready = ($urandom_range(99, 0) < p_rdy);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_op_ready"}, op_ready, 0);
      check({tag, "_wb_ready"}, wb_ready, 0);
      check({tag, "_read_en"},  rf_read_en, 0);
      check({tag, "_write_en"}, rf_write_en, 0);
      check({tag, "_opnd_valid"}, opnd_valid, 0);
      check({tag, "_opnd_rs1"}, opnd_rs1, 0);
      check({tag, "_opnd_rs2"}, opnd_rs2, 0);
   endtask

   int phases [4][3] = '{'{70, 30, 60}, '{90, 90, 50}, '{80, 50, 10}, '{50, 20, 100}};

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]  = $urandom;
         arch[i] = mem[i];
      end
      mem[0]  = 32'hBAD0_0001;
      arch[0] = 32'd0;
      pending = 0; age = 0; losses = 0; mh1 = '0; mh2 = '0;
      rst = 1'b1;
      op_valid = 1'b1; op_rs1 = 5'd1; op_rs2 = 5'd2;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
      opnd_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_checks("por");
      rst = 1'b0;
      op_valid = 1'b0; wb_valid = 1'b0;

      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 400; c++) begin
            drive(phases[p][0], phases[p][1], phases[p][2]);
            cycle();
         end
      end

      // Reach a held pair with execute stalled, then reset mid-hold.
      op_valid = 1'b1; wb_valid = 1'b0; opnd_ready = 1'b0;
      op_rs1 = 5'd5; op_rs2 = 5'd6;
      for (int c = 0; c < 10 && !e_ov; c++) cycle();
      check("reach_hold", e_ov, 1);
      wb_valid = 1'b1; wb_rd = 5'd4;
      rst = 1'b1;
      #1 reset_checks("hold_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      pending = 0; age = 0; losses = 0;
      op_valid = 1'b0; wb_valid = 1'b0;
      cycle();
      check("post_rst_op_ready", op_ready, 1);

      for (int c = 0; c < 200; c++) begin
         drive(80, 60, 40);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
